// File: rtl/hdlverifier_capture_pkg.sv
// Shared types for the multi-channel capture core: FSM states and trigger
// mode encodings used by the config latch.
package hdlverifier_capture_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ARMED,
      POST,
      FULL
   } cap_state_e;

   localparam logic TRIG_LEVEL = 1'b0;
   localparam logic TRIG_EDGE  = 1'b1;
   localparam logic COMB_AND   = 1'b0;
   localparam logic COMB_OR    = 1'b1;

endpackage

// File: rtl/hdlverifier_capture_core_mc_if.sv
// Readout bus of the capture core: read strobe/address in, registered word
// and its valid pulse back one cycle later.
interface hdlverifier_capture_core_mc_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int MEM_W      = 17
);
   logic                  rd;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [MEM_W-1:0]      rd_data;
   logic                  rd_valid;

   modport master (output rd, raddr, input rd_data, rd_valid);
   modport slave  (input rd, raddr, output rd_data, rd_valid);
endinterface

// File: rtl/hdlverifier_capture_sdpram.sv
// Single-clock simple dual-port RAM with a registered read port.
// A read and write to the same address in one cycle returns the old word.
module hdlverifier_capture_sdpram #(
   parameter int MEM_W      = 17,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [MEM_W-1:0]      wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [MEM_W-1:0]      rdata
);
   logic [MEM_W-1:0] mem [2**ADDR_WIDTH];

   // storage is deliberately not reset; captures survive a re-arm
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // registered read; the output register clears on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/hdlverifier_capture_core_mc.sv
// Multi-channel, multi-window capture core. Mask/compare trigger across
// channels plus external/immediate triggers feed a window FSM that writes a
// segmented circular buffer; readout shares the same clock.
module hdlverifier_capture_core_mc
   import hdlverifier_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 2,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clk_enable,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   data,
   input  logic                           ext_trigger,
   input  logic                           immediate,
   input  logic                           run,
   input  logic [ADDR_WIDTH-1:0]          trigger_pos,
   input  logic [ADDR_WIDTH-1:0]          number_of_windows,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   trig_mask,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   trig_value,
   input  logic                           trig_edge,
   input  logic                           trig_combine_or,
   hdlverifier_capture_core_mc_if.slave   rbus,
   output logic                           state_full,
   output logic                           armed,
   output logic [ADDR_WIDTH:0]            captured_window_count
);
   localparam int MEM_W = NUM_CH*DATA_WIDTH + 1;
   localparam int CW    = ADDR_WIDTH + 1;
   localparam int NW_W  = $clog2(ADDR_WIDTH + 1);
   localparam logic [ADDR_WIDTH-1:0] A_ONES = '1;
   localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
   localparam logic [CW-1:0]         C_ONE  = CW'(1);

   cap_state_e                  state_q, state_d;
   logic                        run_d1, prev_q, edge_q, or_q;
   logic [NW_W-1:0]             nw_q, nw_new;
   logic [ADDR_WIDTH-1:0]       wmask_q, wmask_new, tp_q, tp_new;
   logic [NUM_CH*DATA_WIDTH-1:0] mask_q, value_q;
   logic [ADDR_WIDTH-1:0]       waddr_q, waddr_d, base_q, base_d;
   logic [ADDR_WIDTH-1:0]       pre_q, pre_d, post_q, post_d;
   logic [ADDR_WIDTH-1:0]       waddr_inc, wsize_a;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [NUM_CH-1:0]           ch_hit;
   logic                        match, trig, arm, we, wflag, done, last_win, rd_vld_q;

   // clamp window count and pre-trigger depth from the live config inputs
   assign nw_new    = (number_of_windows > ADDR_WIDTH'(ADDR_WIDTH)) ? NW_W'(ADDR_WIDTH)
                                                                    : number_of_windows[NW_W-1:0];
   assign wmask_new = A_ONES >> nw_new;
   assign tp_new    = (trigger_pos > wmask_new) ? wmask_new : trigger_pos;

   // per-channel masked compare
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign ch_hit[c] = ~|((data[c*DATA_WIDTH +: DATA_WIDTH] ^ value_q[c*DATA_WIDTH +: DATA_WIDTH])
                            & mask_q[c*DATA_WIDTH +: DATA_WIDTH]);
   end

   assign match     = (or_q == COMB_OR) ? |ch_hit : &ch_hit;
   assign trig      = ((edge_q == TRIG_EDGE) ? (match & ~prev_q) : match) | ext_trigger | immediate;
   assign arm       = run & ~run_d1;
   assign wsize_a   = wmask_q + A_ONE;
   // next address wraps inside [base, base+wsize-1]
   assign waddr_inc = base_q + ((waddr_q - base_q + A_ONE) & wmask_q);
   assign last_win  = (cnt_q + C_ONE) == (C_ONE << nw_q);

   // config latch on arm, run edge detect and previous-sample match
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_d1  <= 1'b0;
         prev_q  <= 1'b0;
         nw_q    <= '0;
         wmask_q <= A_ONES;
         tp_q    <= '0;
         mask_q  <= '0;
         value_q <= '0;
         edge_q  <= TRIG_LEVEL;
         or_q    <= COMB_AND;
      end else begin
         run_d1 <= run;
         if (clk_enable) prev_q <= match;
         if (arm) begin
            nw_q    <= nw_new;
            wmask_q <= wmask_new;
            tp_q    <= tp_new;
            mask_q  <= trig_mask;
            value_q <= trig_value;
            edge_q  <= trig_edge;
            or_q    <= trig_combine_or;
         end
      end
   end

   // FSM state and capture counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         waddr_q <= '0;
         base_q  <= '0;
         pre_q   <= '0;
         post_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         base_q  <= base_d;
         pre_q   <= pre_d;
         post_q  <= post_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state, counter updates and write control
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      base_d  = base_q;
      pre_d   = pre_q;
      post_d  = post_q;
      cnt_d   = cnt_q;
      we      = 1'b0;
      wflag   = 1'b0;
      done    = 1'b0;
      if (!run) begin
         // abort wins over any trigger or sample this cycle
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (arm) begin
               waddr_d = '0;
               base_d  = '0;
               pre_d   = '0;
               cnt_d   = '0;
               state_d = (tp_new == '0) ? ARMED : PRE;
            end
            PRE: if (clk_enable) begin
               we      = 1'b1;
               waddr_d = waddr_inc;
               pre_d   = pre_q + A_ONE;
               if (pre_d == tp_q) state_d = ARMED;
            end
            ARMED: if (clk_enable) begin
               we      = 1'b1;
               waddr_d = waddr_inc;
               if (trig) begin
                  wflag  = 1'b1;
                  post_d = wmask_q - tp_q;
                  if (post_d == '0) done = 1'b1;
                  else              state_d = POST;
               end
            end
            POST: if (clk_enable) begin
               we      = 1'b1;
               waddr_d = waddr_inc;
               post_d  = post_q - A_ONE;
               if (post_d == '0) done = 1'b1;
            end
            default: ;  // FULL holds until run drops
         endcase
         if (done) begin
            cnt_d   = cnt_q + C_ONE;
            base_d  = base_q + wsize_a;
            waddr_d = base_q + wsize_a;
            pre_d   = '0;
            if (last_win)          state_d = FULL;
            else if (tp_q == '0)   state_d = ARMED;
            else                   state_d = PRE;
         end
      end
   end

   hdlverifier_capture_sdpram #(.MEM_W(MEM_W), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .rst   (reset),
      .we    (we),
      .waddr (waddr_q),
      .wdata ({wflag, data}),
      .re    (rbus.rd),
      .raddr (rbus.raddr),
      .rdata (rbus.rd_data)
   );

   // read valid follows the strobe by one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_vld_q <= 1'b0;
      else       rd_vld_q <= rbus.rd;
   end

   assign rbus.rd_valid         = rd_vld_q;
   assign armed                 = (state_q == ARMED);
   assign state_full            = (state_q == FULL);
   assign captured_window_count = cnt_q;
endmodule

// File: tb/tb_hdlverifier_capture_core_mc.sv
// Directed + randomized bench for the capture core with a sample-level
// reference model: windows are tracked as "samples written / trigger index"
// and buffer addresses are derived with modular arithmetic.
module tb_hdlverifier_capture_core_mc;
   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable, ext_trigger, immediate, run, trig_edge, trig_combine_or;
   logic [15:0] data, trig_mask, trig_value;
   logic [4:0]  trigger_pos, number_of_windows;
   logic        state_full, armed;
   logic [5:0]  captured_window_count;

   hdlverifier_capture_core_mc_if #(.ADDR_WIDTH(5), .MEM_W(17)) rbus ();

   hdlverifier_capture_core_mc dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .data(data),
      .ext_trigger(ext_trigger), .immediate(immediate), .run(run),
      .trigger_pos(trigger_pos), .number_of_windows(number_of_windows),
      .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
      .trig_combine_or(trig_combine_or), .rbus(rbus), .state_full(state_full),
      .armed(armed), .captured_window_count(captured_window_count)
   );

   always #5 clk = ~clk;

   int vec = 0, bad = 0;

   // ---------------- reference model ----------------
   bit          m_cap, m_full, m_prev, m_run_d, m_edge, m_or, m_rdv, m_rdk;
   int          m_win, m_n, m_tpos, m_tp, m_wsize, m_nwin;
   logic [15:0] m_mask, m_val;
   logic [16:0] m_rdd;
   logic [16:0] mmem [32];
   bit          mknown [32];

   function automatic bit m_match(logic [15:0] d);
      bit any = 0, all = 1;
      for (int c = 0; c < 2; c++) begin
         bit h = (((d[c*8 +: 8] ^ m_val[c*8 +: 8]) & m_mask[c*8 +: 8]) == 8'h00);
         any |= h;
         all &= h;
      end
      return m_or ? any : all;
   endfunction

   function automatic bit m_armed();
      return m_cap && m_tpos < 0 && m_n >= m_tp;
   endfunction

   task automatic model_reset();
      m_cap = 0; m_full = 0; m_prev = 0; m_run_d = 0; m_rdv = 0; m_rdk = 0;
      m_win = 0; m_n = 0; m_tpos = -1; m_tp = 0; m_wsize = 32; m_nwin = 1;
      m_mask = '0; m_val = '0; m_edge = 0; m_or = 0;
   endtask

   // advance the model by one clock edge using the inputs currently driven
   task automatic model_step();
      bit mt, trg, hit;
      int a, nw;
      m_rdv = rbus.rd;
      m_rdk = rbus.rd && mknown[rbus.raddr];
      m_rdd = mmem[rbus.raddr];
      mt  = m_match(data);
      trg = (m_edge ? (mt && !m_prev) : mt) || ext_trigger || immediate;
      if (!run) begin
         m_cap = 0; m_full = 0; m_win = 0;
      end else if (!m_cap && !m_full) begin
         if (!m_run_d) begin
            nw      = (number_of_windows > 5) ? 5 : int'(number_of_windows);
            m_wsize = 32 >> nw;
            m_nwin  = 1 << nw;
            m_tp    = (int'(trigger_pos) > m_wsize - 1) ? m_wsize - 1 : int'(trigger_pos);
            m_mask  = trig_mask; m_val = trig_value;
            m_edge  = trig_edge; m_or = trig_combine_or;
            m_cap = 1; m_win = 0; m_n = 0; m_tpos = -1;
         end
      end else if (m_cap && clk_enable) begin
         hit = trg && m_tpos < 0 && m_n >= m_tp;
         a = (m_win * m_wsize + m_n % m_wsize) % 32;
         mmem[a] = {hit, data};
         mknown[a] = 1;
         if (hit) m_tpos = m_n;
         m_n++;
         if (m_tpos >= 0 && m_n - m_tpos == m_wsize - m_tp) begin
            m_win++; m_n = 0; m_tpos = -1;
            if (m_win == m_nwin) begin m_cap = 0; m_full = 1; end
         end
      end
      if (clk_enable) m_prev = mt;
      m_run_d = run;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("armed", 32'(armed), 32'(m_armed()));
      chk("state_full", 32'(state_full), 32'(m_full));
      chk("count", 32'(captured_window_count), 32'(m_win));
      chk("rd_valid", 32'(rbus.rd_valid), 32'(m_rdv));
      if (m_rdk) chk("rd_data", 32'(rbus.rd_data), 32'(m_rdd));
   endtask

   task automatic set_cfg(input int tp, input int nw, input logic [15:0] mk,
                          input logic [15:0] vl, input bit ed, input bit orr);
      trigger_pos = 5'(tp); number_of_windows = 5'(nw);
      trig_mask = mk; trig_value = vl; trig_edge = ed; trig_combine_or = orr;
   endtask

   task automatic readout(output logic [31:0] fl);
      fl = '0;
      for (int a = 0; a < 32; a++) begin
         rbus.rd = 1'b1; rbus.raddr = 5'(a);
         tick();
         fl[a] = rbus.rd_data[16];
      end
      rbus.rd = 1'b0;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_armed"}, 32'(armed), 32'd0);
      chk({tag, "_full"}, 32'(state_full), 32'd0);
      chk({tag, "_count"}, 32'(captured_window_count), 32'd0);
      chk({tag, "_rd_valid"}, 32'(rbus.rd_valid), 32'd0);
      chk({tag, "_rd_data"}, 32'(rbus.rd_data), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      logic [31:0] fl;
      bit          hit_post;
      reset = 1'b1; clk_enable = 1'b0; data = '0; ext_trigger = 0; immediate = 0; run = 0;
      set_cfg(0, 0, 16'h0, 16'h0, 0, 0);
      rbus.rd = 1'b0; rbus.raddr = '0;
      model_reset();
      for (int a = 0; a < 32; a++) mknown[a] = 0;
      #12;
      chk_zero_outputs("reset");
      @(negedge clk) reset = 1'b0;

      // T1: single window, tp=8, ch0 == 0x42 at sample 20
      clk_enable = 1'b1; data = 16'h0101;
      set_cfg(8, 0, 16'h00FF, 16'h0042, 0, 0);
      run = 1'b1; tick();
      for (int i = 0; i < 44; i++) begin
         d = 16'($urandom);
         if (d[7:0] == 8'h42) d[7:0] = 8'h43;
         if (i == 20) d[7:0] = 8'h42;
         data = d; tick();
         if (i == 42) chk("t1_not_full_yet", 32'(state_full), 32'd0);
      end
      chk("t1_full", 32'(state_full), 32'd1);
      chk("t1_count", 32'(captured_window_count), 32'd1);
      readout(fl);
      chk("t1_flag_map", fl, 32'h0010_0000);
      run = 1'b0; tick();
      chk("t1_abort_count", 32'(captured_window_count), 32'd0);

      // T2: four windows of 8, tp=0, immediate held
      set_cfg(0, 2, 16'hFFFF, 16'h0000, 0, 0);
      immediate = 1'b1; run = 1'b1; tick();
      for (int i = 0; i < 32; i++) begin
         data = 16'($urandom); tick();
         if (i % 8 == 7) chk("t2_count_step", 32'(captured_window_count), 32'(i / 8 + 1));
      end
      chk("t2_full", 32'(state_full), 32'd1);
      readout(fl);
      chk("t2_flag_map", fl, 32'h0101_0101);
      immediate = 1'b0; run = 1'b0; tick();

      // T3: ch1 matches for 5 samples; edge vs level, OR combine, 2-sample windows
      for (int mode = 1; mode >= 0; mode--) begin
         data = 16'h0101;
         set_cfg(0, 4, 16'hFFFF, 16'h5AC3, mode[0], 1);
         run = 1'b1; tick();
         for (int i = 0; i < 12; i++) begin
            d = 16'($urandom);
            if (d[7:0] == 8'hC3) d[7:0] = 8'h3C;
            if (d[15:8] == 8'h5A) d[15:8] = 8'hA5;
            if (i >= 3 && i <= 7) d[15:8] = 8'h5A;
            data = d; tick();
         end
         chk(mode ? "t3_edge_count" : "t3_level_count", 32'(captured_window_count),
             mode ? 32'd1 : 32'd3);
         run = 1'b0; tick();
      end

      // T4: tp=31 in one window; PRE ignores the held trigger
      set_cfg(31, 0, 16'h0000, 16'h0000, 0, 0);
      immediate = 1'b1; run = 1'b1; tick();
      for (int i = 0; i < 32; i++) begin
         data = 16'($urandom); tick();
         if (i == 30) begin
            chk("t4_armed_after_31", 32'(armed), 32'd1);
            chk("t4_not_full_after_31", 32'(state_full), 32'd0);
         end
      end
      chk("t4_full", 32'(state_full), 32'd1);
      readout(fl);
      chk("t4_flag_map", fl, 32'h8000_0000);
      immediate = 1'b0; run = 1'b0; tick();

      // T5: 50% clk_enable, abort mid-POST, then re-arm with random traffic
      set_cfg(3, 1, 16'hFFFF, 16'h1234, 0, 0);
      run = 1'b1; tick();
      hit_post = 0;
      for (int i = 0; i < 200 && !hit_post; i++) begin
         clk_enable = 1'($urandom); data = 16'($urandom);
         ext_trigger = m_armed();
         tick();
         hit_post = m_cap && m_tpos >= 0;
      end
      chk("t5_reached_post", 32'(hit_post), 32'd1);
      ext_trigger = 1'b0;
      for (int i = 0; i < 2; i++) begin
         clk_enable = 1'($urandom); data = 16'($urandom); tick();
      end
      run = 1'b0; tick();
      chk("t5_abort_count", 32'(captured_window_count), 32'd0);
      chk("t5_abort_armed", 32'(armed), 32'd0);
      run = 1'b1; tick();
      for (int i = 0; i < 600 && !m_full; i++) begin
         clk_enable = 1'($urandom); data = 16'($urandom);
         ext_trigger = ($urandom_range(7) == 0);
         rbus.rd = 1'($urandom); rbus.raddr = 5'($urandom);
         tick();
      end
      ext_trigger = 1'b0; rbus.rd = 1'b0; clk_enable = 1'b1;
      chk("t5_rearm_full", 32'(state_full), 32'd1);
      chk("t5_rearm_count", 32'(captured_window_count), 32'd2);
      readout(fl);
      run = 1'b0; tick();

      // T6: trigger_pos beyond the window (31 with nw=1; 40 does not fit the
      // 5-bit port) clamps to 15; then reset while ARMED
      set_cfg(31, 1, 16'h0000, 16'h0000, 0, 0);
      run = 1'b1; tick();
      for (int i = 0; i < 15; i++) begin
         data = 16'($urandom);
         if (i == 14) begin rbus.rd = 1'b1; rbus.raddr = 5'd3; end
         tick();
         if (i == 13) chk("t6_not_armed_at_14", 32'(armed), 32'd0);
      end
      chk("t6_armed_at_15", 32'(armed), 32'd1);
      reset = 1'b1;
      #1;
      chk_zero_outputs("t6_reset");
      model_reset();
      run = 1'b0; rbus.rd = 1'b0;
      @(negedge clk) reset = 1'b0;
      tick();
      chk("t6_idle_after_reset", 32'(armed), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
